oled_rect_fill: RTL and testbench

//  Upstream byte-stream generator for the OLED driver: accepts one filled-rectangle

---
 rtl/oled_rect_fill_if.sv | 48 ++++
 rtl/oled_rect_fill.sv | 199 +++++++++++++++++++
 tb/tb_oled_rect_fill.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_rect_fill_if.sv
// Request and output byte-stream bundle for the rectangle-fill generator.
// The slave modport is the generator's view: it takes rectangle requests and
// produces the command/pixel byte stream. The master modport is the opposite side.
interface oled_rect_fill_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_x0;
  logic [5:0] req_y0;
  logic [6:0] req_x1;
  logic [5:0] req_y1;
  logic [7:0] req_color;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_dc;
  logic       out_last;

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_x0,
    input  req_y0,
    input  req_x1,
    input  req_y1,
    input  req_color,
    output out_valid,
    input  out_ready,
    output out_byte,
    output out_dc,
    output out_last
  );

  modport master (
    output req_valid,
    input  req_ready,
    output req_x0,
    output req_y0,
    output req_x1,
    output req_y1,
    output req_color,
    input  out_valid,
    output out_ready,
    input  out_byte,
    input  out_dc,
    input  out_last
  );
endinterface

// File: rtl/oled_rect_fill.sv
// Filled-rectangle byte-stream generator for the SSD1331 OLED driver.
// Takes one (x0,y0,x1,y1,colour) request, emits the six window commands
// (0x15 x0 x1 0x75 y0 y1, dc=0) and then one RGB332 colour byte per pixel
// (dc=1), flagging the final byte with out_last. All stream outputs come
// straight from flops so they hold still while the consumer stalls.
module oled_rect_fill #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64
) (
  input  logic              clk,
  input  logic              reset,
  oled_rect_fill_if.slave   bus,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  x0_q, x0_d;
  logic [6:0]  x1_q, x1_d;
  logic [5:0]  y0_q, y0_d;
  logic [5:0]  y1_q, y1_d;
  logic [7:0]  color_q, color_d;
  logic [2:0]  cmd_idx_q, cmd_idx_d;
  logic [12:0] pix_cnt_q, pix_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        out_dc_q, out_dc_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        out_fire;
  logic        req_ok;
  logic [6:0]  y1_wide;
  logic [12:0] span_x;
  logic [12:0] span_y;
  logic [12:0] pix_total;
  logic [2:0]  next_idx;
  logic [7:0]  next_cmd_byte;

  assign out_fire  = out_valid_q && bus.out_ready;

  // y1 is widened so the bound check against HEIGHT stays meaningful for any
  // panel height, not just ones that fill the 6-bit coordinate range.
  assign y1_wide   = {1'b0, bus.req_y1};
  assign req_ok    = (bus.req_x0 <= bus.req_x1) &&
                     (bus.req_y0 <= bus.req_y1) &&
                     (bus.req_x1 < 7'(WIDTH)) &&
                     (y1_wide < 7'(HEIGHT));

  // Pixel count is formed at acceptance; 96x64 = 6144 fits in 13 bits.
  assign span_x    = 13'(bus.req_x1) - 13'(bus.req_x0) + 13'd1;
  assign span_y    = 13'(bus.req_y1) - 13'(bus.req_y0) + 13'd1;
  assign pix_total = span_x * span_y;

  assign next_idx  = cmd_idx_q + 3'd1;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_dc    = out_dc_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign err           = err_q;

  // Select the command byte that follows the one currently on the output.
  always_comb begin
    next_cmd_byte = 8'h15;
    case (next_idx)
      3'd1:    next_cmd_byte = {1'b0, x0_q};
      3'd2:    next_cmd_byte = {1'b0, x1_q};
      3'd3:    next_cmd_byte = 8'h75;
      3'd4:    next_cmd_byte = {2'b00, y0_q};
      3'd5:    next_cmd_byte = {2'b00, y1_q};
      default: next_cmd_byte = 8'h15;
    endcase
  end

  // Next-state and next-output logic; output flops only change on acceptance
  // or on a downstream handshake, which keeps them stable across stalls.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    color_d     = color_q;
    cmd_idx_d   = cmd_idx_q;
    pix_cnt_d   = pix_cnt_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_dc_d    = out_dc_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_ok) begin
            x0_d        = bus.req_x0;
            x1_d        = bus.req_x1;
            y0_d        = bus.req_y0;
            y1_d        = bus.req_y1;
            color_d     = bus.req_color;
            pix_cnt_d   = pix_total;
            cmd_idx_d   = 3'd0;
            out_valid_d = 1'b1;
            out_byte_d  = 8'h15;
            out_dc_d    = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b1;
            state_d     = CMD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      CMD: begin
        if (out_fire) begin
          if (cmd_idx_q == 3'd5) begin
            out_byte_d = color_q;
            out_dc_d   = 1'b1;
            out_last_d = (pix_cnt_q == 13'd1);
            state_d    = DATA;
          end else begin
            cmd_idx_d  = next_idx;
            out_byte_d = next_cmd_byte;
          end
        end
      end

      DATA: begin
        if (out_fire) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_byte_d  = 8'h00;
            out_dc_d    = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            pix_cnt_d   = 13'd0;
            cmd_idx_d   = 3'd0;
            state_d     = IDLE;
          end else begin
            pix_cnt_d  = pix_cnt_q - 13'd1;
            out_last_d = (pix_cnt_q == 13'd2);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any rectangle in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x0_q        <= 7'd0;
      x1_q        <= 7'd0;
      y0_q        <= 6'd0;
      y1_q        <= 6'd0;
      color_q     <= 8'd0;
      cmd_idx_q   <= 3'd0;
      pix_cnt_q   <= 13'd0;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'd0;
      out_dc_q    <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      cmd_idx_q   <= cmd_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_dc_q    <= out_dc_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_oled_rect_fill.sv
// Testbench for oled_rect_fill: a queue-based model of the expected byte stream
// is filled on every accepted request, and a single negedge process compares
// every DUT output against it each cycle.
module tb_oled_rect_fill;

  logic clk;
  logic reset;
  logic busy;
  logic err;

  oled_rect_fill_if bus_if();

  oled_rect_fill #(.WIDTH(96), .HEIGHT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       dc;
    logic       last;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  exp_t log_q[$];

  int   checks = 0;
  int   errors = 0;
  bit   model_busy = 0;
  bit   err_exp = 0;
  bit   stall_mode = 0;
  int   data_seen = 0;
  int   cmd_seen = 0;
  int   last_seen = 0;
  int   err_seen = 0;
  int   stall_seen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reqIsValid(input int x0, input int y0, input int x1, input int y1);
    return (x0 <= x1) && (y0 <= y1) && (x1 <= 95) && (y1 <= 63);
  endfunction

  // Model: an accepted rectangle produces the window commands, then one colour
  // byte per covered pixel with the last one flagged.
  task automatic modelAccept(input int x0, input int y0, input int x1, input int y1, input logic [7:0] col);
    int n;
    exp_t e;
    logic [7:0] cmds [6];
    cmds[0] = 8'h15;
    cmds[1] = 8'(x0);
    cmds[2] = 8'(x1);
    cmds[3] = 8'h75;
    cmds[4] = 8'(y0);
    cmds[5] = 8'(y1);
    for (int i = 0; i < 6; i++) begin
      e.dc = 1'b0; e.last = 1'b0; e.b = cmds[i];
      exp_q.push_back(e);
    end
    n = (x1 - x0 + 1) * (y1 - y0 + 1);
    for (int i = 0; i < n; i++) begin
      e.dc = 1'b1; e.last = (i == n - 1); e.b = col;
      exp_q.push_back(e);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by whatever
  // handshakes happen on the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      checkOutput("rst_out_byte",  32'(bus_if.out_byte),  32'd0);
      checkOutput("rst_out_dc",    32'(bus_if.out_dc),    32'd0);
      checkOutput("rst_out_last",  32'(bus_if.out_last),  32'd0);
      checkOutput("rst_busy",      32'(busy),             32'd0);
      checkOutput("rst_err",       32'(err),              32'd0);
      checkOutput("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
      exp_q.delete();
      model_busy = 0;
      err_exp = 0;
    end else begin
      checkOutput("err",       32'(err),              32'(err_exp));
      checkOutput("busy",      32'(busy),             32'(model_busy));
      checkOutput("req_ready", 32'(bus_if.req_ready), 32'(!model_busy));
      checkOutput("out_valid", 32'(bus_if.out_valid), 32'(exp_q.size() != 0));
      if (bus_if.out_valid && exp_q.size() != 0) begin
        checkOutput("out_byte", 32'(bus_if.out_byte), 32'(exp_q[0].b));
        checkOutput("out_dc",   32'(bus_if.out_dc),   32'(exp_q[0].dc));
        checkOutput("out_last", 32'(bus_if.out_last), 32'(exp_q[0].last));
      end
      err_exp = 0;
      if (err) err_seen++;
      if (bus_if.out_valid && bus_if.out_ready && exp_q.size() != 0) begin
        log_q.push_back(exp_q[0]);
        if (exp_q[0].dc) data_seen++;
        else cmd_seen++;
        if (exp_q[0].last) begin
          last_seen++;
          model_busy = 0;
        end
        void'(exp_q.pop_front());
      end else if (bus_if.out_valid && !bus_if.out_ready) begin
        stall_seen++;
      end
      if (bus_if.req_valid && bus_if.req_ready) begin
        if (reqIsValid(int'(bus_if.req_x0), int'(bus_if.req_y0),
                       int'(bus_if.req_x1), int'(bus_if.req_y1))) begin
          modelAccept(int'(bus_if.req_x0), int'(bus_if.req_y0),
                      int'(bus_if.req_x1), int'(bus_if.req_y1), bus_if.req_color);
          model_busy = 1;
        end else begin
          err_exp = 1;
        end
      end
    end
  end

  // Downstream ready: always high, or randomly stalling.
  initial begin
    bus_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_if.out_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic applyStimulus(input logic [6:0] x0, input logic [5:0] y0,
                               input logic [6:0] x1, input logic [5:0] y1,
                               input logic [7:0] col);
    @(posedge clk);
    #1;
    bus_if.req_x0    = x0;
    bus_if.req_y0    = y0;
    bus_if.req_x1    = x1;
    bus_if.req_y1    = y1;
    bus_if.req_color = col;
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (!busy && !model_busy && exp_q.size() == 0) break;
    end
    if (i == budget) begin
      errors++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles", name, budget);
    end
  endtask

  task automatic clearStats();
    data_seen = 0; cmd_seen = 0; last_seen = 0; err_seen = 0; stall_seen = 0;
    log_q.delete();
  endtask

  task automatic checkRect1Log(input string name);
    logic [7:0] ref_bytes [15];
    ref_bytes = '{8'h15, 8'h02, 8'h04, 8'h75, 8'h03, 8'h05,
                  8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0};
    checkOutput({name, "_len"}, 32'(log_q.size()), 32'd15);
    for (int i = 0; i < 15 && i < log_q.size(); i++) begin
      checkOutput({name, "_byte"}, 32'(log_q[i].b),    32'(ref_bytes[i]));
      checkOutput({name, "_dc"},   32'(log_q[i].dc),   32'(i >= 6));
      checkOutput({name, "_last"}, 32'(log_q[i].last), 32'(i == 14));
    end
  endtask

  initial begin
    logic [6:0] rx0, rx1;
    logic [5:0] ry0, ry1;
    int loops;

    reset = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_x0 = '0; bus_if.req_y0 = '0;
    bus_if.req_x1 = '0; bus_if.req_y1 = '0;
    bus_if.req_color = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    $display("[TB] reset released");

    // Rect (2,3,4,5) colour E0 at full throughput.
    clearStats();
    applyStimulus(7'd2, 6'd3, 7'd4, 6'd5, 8'hE0);
    waitDone(100, "t1");
    checkOutput("t1_data_count", 32'(data_seen), 32'd9);
    checkOutput("t1_cmd_count",  32'(cmd_seen),  32'd6);
    checkOutput("t1_stalls",     32'(stall_seen), 32'd0);
    checkRect1Log("t1");

    // Single pixel.
    clearStats();
    applyStimulus(7'd7, 6'd7, 7'd7, 6'd7, 8'h1C);
    waitDone(50, "t2");
    checkOutput("t2_data_count", 32'(data_seen), 32'd1);
    checkOutput("t2_last_count", 32'(last_seen), 32'd1);

    // Full screen, with a request presented mid-stream that must be ignored.
    clearStats();
    applyStimulus(7'd0, 6'd0, 7'd95, 6'd63, 8'h03);
    repeat (5) @(posedge clk);
    #1;
    bus_if.req_x0 = 7'd1; bus_if.req_y0 = 6'd1;
    bus_if.req_x1 = 7'd2; bus_if.req_y1 = 6'd2;
    bus_if.req_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    waitDone(7000, "t3");
    checkOutput("t3_data_count", 32'(data_seen), 32'd6144);
    checkOutput("t3_last_count", 32'(last_seen), 32'd1);

    // Rect 1 again with random downstream stalls.
    clearStats();
    stall_mode = 1;
    applyStimulus(7'd2, 6'd3, 7'd4, 6'd5, 8'hE0);
    waitDone(500, "t4");
    stall_mode = 0;
    checkRect1Log("t4");
    checkOutput("t4_saw_stall", 32'(stall_seen != 0), 32'd1);

    // Invalid requests.
    clearStats();
    applyStimulus(7'd10, 6'd0, 7'd5, 6'd0, 8'hAA);
    waitDone(20, "t5a");
    applyStimulus(7'd0, 6'd0, 7'd96, 6'd0, 8'hAA);
    waitDone(20, "t5b");
    applyStimulus(7'd0, 6'd5, 7'd0, 6'd4, 8'hAA);
    waitDone(20, "t5c");
    checkOutput("t5_err_pulses", 32'(err_seen), 32'd3);
    checkOutput("t5_bytes", 32'(data_seen + cmd_seen), 32'd0);

    // Reset after the 3rd data byte of rect 1.
    clearStats();
    applyStimulus(7'd2, 6'd3, 7'd4, 6'd5, 8'hE0);
    loops = 0;
    while (data_seen < 3 && loops < 100) begin
      @(posedge clk);
      #1;
      loops++;
    end
    if (data_seen < 3) begin
      errors++;
      $display("[TB] FAIL t6_wait: data bytes seen=%0d required=3", data_seen);
    end
    reset = 1'b1;
    #1;
    checkOutput("t6_out_valid", 32'(bus_if.out_valid), 32'd0);
    checkOutput("t6_busy",      32'(busy),             32'd0);
    checkOutput("t6_req_ready", 32'(bus_if.req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    checkOutput("t6_abandoned", 32'(data_seen), 32'd3);
    clearStats();
    applyStimulus(7'd0, 6'd0, 7'd1, 6'd1, 8'h5A);
    waitDone(50, "t6b");
    checkOutput("t6b_data_count", 32'(data_seen), 32'd4);

    // Randomised rectangles, some invalid, with and without stalls.
    for (int k = 0; k < 25; k++) begin
      stall_mode = ($urandom_range(0, 1) == 1);
      rx0 = 7'($urandom_range(0, 100));
      rx1 = 7'(int'(rx0) + $urandom_range(0, 12));
      ry0 = 6'($urandom_range(0, 63));
      ry1 = 6'(int'(ry0) + $urandom_range(0, 12));
      if ($urandom_range(0, 4) == 0) rx1 = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 4) == 0) ry1 = 6'($urandom_range(0, 63));
      applyStimulus(rx0, ry0, rx1, ry1, 8'($urandom));
      waitDone(2000, "rand");
    end
    stall_mode = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
